// File: rtl/bb_pkg.sv
// Shared baseband definitions: access-code length, popcount width and the
// correlator state encoding.
package bb_pkg;

    localparam int SYNC_LEN = 64;
    localparam int POP_W    = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        FOUND  = 2'd2
    } corr_state_e;

endpackage

// File: rtl/syncword_popcount.sv
// Combinational count of set bits in the 64-bit mismatch vector
// (window XOR syncword); the result is 0..64 and fits in 7 bits.
module syncword_popcount
    import bb_pkg::*;
(
    input  logic [SYNC_LEN-1:0] data,
    output logic [POP_W-1:0]    count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < SYNC_LEN; i++) begin
            count = count + POP_W'(data[i]);
        end
    end

endmodule

// File: rtl/syncword_correlator.sv
// Sliding 64-bit access-code correlator: shifts rxbit on each p_1us, registers the
// mismatch popcount one clk later and compares it against the threshold the clk after.
module syncword_correlator
    import bb_pkg::*;
(
    input  logic                clk_6M,
    input  logic                rst,
    input  logic                p_1us,
    input  logic                rxbit,
    input  logic                search_en,
    input  logic [63:0]         syncword,
    input  logic [5:0]          regi_corr_threshold,
    input  logic [9:0]          regi_search_win,
    output logic                rx_trailer_st_p,
    output logic                sync_found,
    output logic                sync_timeout_p,
    output logic [6:0]          corr_errors,
    output corr_state_e         state_dbg
);

    corr_state_e          state_q, state_d;
    logic [SYNC_LEN-1:0]  window_q;
    logic [6:0]           bit_cnt_q;
    logic [9:0]           us_cnt_q;
    logic                 shift_q;
    logic                 pop_vld_q;
    logic [POP_W-1:0]     pop_q;
    logic [POP_W-1:0]     pop_now;

    logic                 rx_q, rx_d;
    logic                 found_q, found_d;
    logic                 to_q, to_d;
    logic [6:0]           err_q, err_d;
    logic                 start;
    logic                 match;
    logic                 expire;

    syncword_popcount u_popcount (
        .data  (window_q ^ syncword),
        .count (pop_now)
    );

    // pop_vld_q marks the single clk in which pop_q reflects the newest shifted bit.
    assign match  = pop_vld_q && (bit_cnt_q == 7'(SYNC_LEN))
                    && (pop_q <= {1'b0, regi_corr_threshold});
    assign expire = pop_vld_q && (regi_search_win != 10'd0)
                    && (us_cnt_q >= regi_search_win);

    // Handshake: rx_trailer_st_p acts as a valid held high until the header stage
    // consumes it with p_1us as ready; it drops the clk after that coincidence.
    always_comb begin
        state_d = state_q;
        rx_d    = rx_q;
        found_d = found_q;
        to_d    = 1'b0;
        err_d   = err_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (search_en) begin
                    state_d = SEARCH;
                    start   = 1'b1;
                    err_d   = '0;
                end
            end
            SEARCH: begin
                if (!search_en) begin
                    state_d = IDLE;
                end else if (match) begin
                    state_d = FOUND;
                    rx_d    = 1'b1;
                    found_d = 1'b1;
                    err_d   = pop_q;
                end else if (expire) begin
                    state_d = IDLE;
                    to_d    = 1'b1;
                end
            end
            FOUND: begin
                if (!search_en) begin
                    state_d = IDLE;
                    rx_d    = 1'b0;
                    found_d = 1'b0;
                end else if (rx_q && p_1us) begin
                    rx_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                rx_d    = 1'b0;
                found_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rx_q    <= 1'b0;
            found_q <= 1'b0;
            to_q    <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            rx_q    <= rx_d;
            found_q <= found_d;
            to_q    <= to_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst) begin
            window_q  <= '0;
            bit_cnt_q <= '0;
            us_cnt_q  <= '0;
            shift_q   <= 1'b0;
            pop_vld_q <= 1'b0;
            pop_q     <= '0;
        end else if (start) begin
            window_q  <= '0;
            bit_cnt_q <= '0;
            us_cnt_q  <= '0;
            shift_q   <= 1'b0;
            pop_vld_q <= 1'b0;
        end else begin
            shift_q   <= 1'b0;
            pop_vld_q <= shift_q;
            if (shift_q) begin
                pop_q <= pop_now;
            end
            if (state_q == SEARCH && search_en && p_1us) begin
                window_q <= {window_q[SYNC_LEN-2:0], rxbit};
                shift_q  <= 1'b1;
                us_cnt_q <= us_cnt_q + 10'd1;
                if (bit_cnt_q != 7'(SYNC_LEN)) begin
                    bit_cnt_q <= bit_cnt_q + 7'd1;
                end
            end
        end
    end

    assign rx_trailer_st_p = rx_q;
    assign sync_found      = found_q;
    assign sync_timeout_p  = to_q;
    assign corr_errors     = err_q;
    assign state_dbg       = state_q;

endmodule

// File: doc/syncword_correlator.md
SYNCWORD_CORRELATOR -- requirements
Module: syncword_correlator

Interface
REQ-001 SHALL have port clk_6M, input, 1 bit: 6 MHz system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port p_1us, input, 1 bit: one-clk_6M strobe every 1 us; it marks the rxbit sampling instant.
REQ-004 SHALL have port rxbit, input, 1 bit: demodulated receive bit, valid when p_1us is high.
REQ-005 SHALL have port search_en, input, 1 bit: correlation window request (page/inquiry/conns receive slot).
REQ-006 SHALL have port syncword, input, 64 bits: expected access code; bit 63 is received first, bit 0 last.
REQ-007 SHALL have port regi_corr_threshold, input, 6 bits: maximum tolerated bit mismatches.
REQ-008 SHALL have port regi_search_win, input, 10 bits: search window length in us, counted from search start.
REQ-009 SHALL have port rx_trailer_st_p, output, 1 bit: sync-found indication to the header stage, consumed as rx_trailer_st_p & p_1us.
REQ-010 SHALL have port sync_found, output, 1 bit: level, high from detection until search_en falls.
REQ-011 SHALL have port sync_timeout_p, output, 1 bit: one-clk pulse when the window expires with no detection.
REQ-012 SHALL have port corr_errors, output, 7 bits: mismatch count at detection, held until the next search start.

Function
REQ-013 SHALL implement FSM states IDLE, SEARCH, FOUND, with all outputs low and corr_errors=0 in IDLE after reset.
REQ-014 SHALL move IDLE->SEARCH on the first clk with search_en=1, clearing the window, bit counter and us counter.
REQ-015 In SEARCH, on each p_1us, SHALL shift: window <= {window[62:0], rxbit}; bit counter saturates at 64; us counter increments.
REQ-016 SHALL register the 64-bit mismatch popcount (window XOR syncword) one clk after the shift; the compare uses that registered value.
REQ-017 SHALL declare a match when bit counter = 64 and popcount <= regi_corr_threshold, evaluated in the clk after popcount registration.
REQ-018 On a match, SHALL enter FOUND, set rx_trailer_st_p, set sync_found, and load corr_errors; latency from the sampling p_1us to rx_trailer_st_p high is 2 clk_6M.
REQ-019 SHALL clear rx_trailer_st_p on the clk after rx_trailer_st_p & p_1us, so exactly one p_1us sees it high.
REQ-020 SHALL raise sync_timeout_p for one clk and return to IDLE when the us counter reaches regi_search_win in SEARCH with no match; a match on the same bit takes priority over timeout.
REQ-021 regi_search_win=0 SHALL mean unlimited window (no timeout).
REQ-022 search_en falling in SEARCH SHALL abort to IDLE with no pulse; in FOUND it SHALL return to IDLE and clear sync_found.
REQ-023 SHALL perform no further detection in FOUND (one detection per window); re-arming requires search_en low for at least one clk.
REQ-024 SHALL ignore p_1us in IDLE and FOUND; the window content is don't-care there.

Reset
REQ-025 rst SHALL asynchronously force IDLE, clear the window, counters, popcount register and all outputs, including mid-search or mid-pulse.
REQ-026 After rst release with search_en already high, SHALL enter SEARCH on the first clk.

Structure
REQ-027 SHALL take the state enum and SYNC_LEN=64 from the shared baseband package (bb_pkg).
REQ-028 SHALL place the 64-bit popcount in a sub-module syncword_popcount (combinational, 7-bit result).
REQ-029 SHALL stay within 120-400 RTL lines with no memories.

Verification
REQ-030 Exact match: 10 random bits then 64 bits of syncword, threshold=0 -> rx_trailer_st_p high 2 clk after the 74th p_1us; corr_errors=0.
REQ-031 Errors at the threshold: 7 flipped bits, threshold=7 -> detect with corr_errors=7; threshold=6 -> no detect, sync_timeout_p at us=regi_search_win.
REQ-032 Timeout: regi_search_win=100 with noise only -> single sync_timeout_p after the 100th p_1us, state IDLE, sync_found=0.
REQ-033 Abort: search_en dropped at us 40 -> IDLE, no pulses; re-raise and a valid syncword -> normal detection.
REQ-034 Handshake: across the detection, count the cycles where rx_trailer_st_p & p_1us is high -> exactly 1; sync_found stays high until search_en falls.
REQ-035 Reset mid-search at us 50, then release -> all outputs 0; a fresh window detects a syncword sent from bit 0.
